// File: rtl/onchip_mem_port_arbiter.sv
// Two-master round-robin arbiter in front of one Avalon-MM port of the on-chip memory.
// A master may keep the port for up to HOLD_MAX consecutive grants while the other waits;
// reads return one cycle after acceptance and readdatavalid is steered to the issuer.
module onchip_mem_port_arbiter #(
   parameter int unsigned ADDR_W   = 6,
   parameter int unsigned DATA_W   = 128,
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [ADDR_W-1:0]     m0_address,
   input  logic                  m0_read,
   input  logic                  m0_write,
   input  logic [DATA_W-1:0]     m0_writedata,
   input  logic [DATA_W/8-1:0]   m0_byteenable,
   output logic                  m0_waitrequest,
   output logic [DATA_W-1:0]     m0_readdata,
   output logic                  m0_readdatavalid,
   input  logic [ADDR_W-1:0]     m1_address,
   input  logic                  m1_read,
   input  logic                  m1_write,
   input  logic [DATA_W-1:0]     m1_writedata,
   input  logic [DATA_W/8-1:0]   m1_byteenable,
   output logic                  m1_waitrequest,
   output logic [DATA_W-1:0]     m1_readdata,
   output logic                  m1_readdatavalid,
   output logic [ADDR_W-1:0]     mem_address,
   output logic                  mem_chipselect,
   output logic                  mem_write,
   output logic [DATA_W-1:0]     mem_writedata,
   output logic [DATA_W/8-1:0]   mem_byteenable,
   output logic                  mem_clken,
   input  logic [DATA_W-1:0]     mem_readdata
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] OWN0 = 2'd1;
   localparam logic [1:0] OWN1 = 2'd2;

   localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

   logic [1:0] state_q, state_d;
   logic [3:0] hold_cnt_q, hold_cnt_d;
   logic       last_q, last_d;
   logic [1:0] rd_tag_q, rd_tag_d;   // {valid, master}
   logic       clken_q;

   logic req0, req1;
   logic owner_vld, owner, own_req, oth_req;
   logic gnt_vld, gnt;
   logic sel, sel_read, sel_write;

   // Grant decision; nothing is granted until the memory clock enable is up after reset.
   always_comb begin
      req0      = m0_read | m0_write;
      req1      = m1_read | m1_write;
      owner_vld = (state_q == OWN0) || (state_q == OWN1);
      owner     = (state_q == OWN1);
      own_req   = owner ? req1 : req0;
      oth_req   = owner ? req0 : req1;
      gnt_vld   = 1'b0;
      gnt       = 1'b0;
      if (!clken_q) begin
         gnt_vld = 1'b0;
      end else if (owner_vld) begin
         if (own_req && (!oth_req || (hold_cnt_q < HOLD_LIM))) begin
            gnt_vld = 1'b1;
            gnt     = owner;
         end else if (oth_req) begin
            gnt_vld = 1'b1;
            gnt     = ~owner;
         end
      end else begin
         if (req0 && req1) begin
            gnt_vld = 1'b1;
            gnt     = ~last_q;
         end else if (req0) begin
            gnt_vld = 1'b1;
            gnt     = 1'b0;
         end else if (req1) begin
            gnt_vld = 1'b1;
            gnt     = 1'b1;
         end
      end
   end

   // Next-state for ownership, hold counter, tie-break history and read tag.
   always_comb begin
      sel_read  = gnt ? m1_read : m0_read;
      sel_write = gnt ? m1_write : m0_write;
      state_d   = gnt_vld ? (gnt ? OWN1 : OWN0) : IDLE;
      last_d    = gnt_vld ? gnt : last_q;
      if (!gnt_vld) begin
         hold_cnt_d = 4'd0;
      end else if (owner_vld && (owner == gnt)) begin
         hold_cnt_d = (hold_cnt_q == 4'hF) ? 4'hF : hold_cnt_q + 4'd1;
      end else begin
         hold_cnt_d = 4'd1;
      end
      // Write wins when a master illegally asserts both.
      rd_tag_d = {gnt_vld & sel_read & ~sel_write, gnt};
   end

   // State registers; reset also drops any read still in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         hold_cnt_q <= 4'd0;
         last_q     <= 1'b1;
         rd_tag_q   <= 2'b00;
         clken_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         last_q     <= last_d;
         rd_tag_q   <= rd_tag_d;
         clken_q    <= 1'b1;
      end
   end

   // Memory-side mux; with no grant it follows the last granted master (values are don't-care).
   always_comb begin
      sel            = gnt_vld ? gnt : last_q;
      mem_address    = sel ? m1_address    : m0_address;
      mem_writedata  = sel ? m1_writedata  : m0_writedata;
      mem_byteenable = sel ? m1_byteenable : m0_byteenable;
      mem_chipselect = gnt_vld;
      mem_write      = gnt_vld & sel_write;
      mem_clken      = clken_q;
   end

   // Master-side handshake and read return.
   always_comb begin
      m0_waitrequest   = ~(gnt_vld & ~gnt);
      m1_waitrequest   = ~(gnt_vld & gnt);
      m0_readdata      = mem_readdata;
      m1_readdata      = mem_readdata;
      m0_readdatavalid = rd_tag_q[1] & ~rd_tag_q[0];
      m1_readdatavalid = rd_tag_q[1] & rd_tag_q[0];
   end

endmodule
